// File: rtl/param_memory_pkg.sv
// Shared types and defaults for the parametrised core memory.
package param_memory_pkg;

   localparam int DW_DEF     = 32;
   localparam int AW_DEF     = 11;
   localparam int RD_LAT_DEF = 1;
   localparam int CNT_W      = 4;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      WAIT,
      RESP
   } state_t;

endpackage

// File: rtl/param_memory_if.sv
// Request/response channel between the core FSM and param_memory.
interface param_memory_if
   import param_memory_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int AW = AW_DEF
);

   logic            req_valid;
   logic            req_ready;
   logic            req_write;
   logic [AW-1:0]   req_addr;
   logic [DW-1:0]   req_wdata;
   logic [DW/8-1:0] req_wstrb;
   logic            rsp_valid;
   logic            rsp_ready;
   logic [DW-1:0]   rsp_rdata;

   modport master (
      output req_valid, req_write, req_addr,
      output req_wdata, req_wstrb, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata
   );

   modport slave (
      input  req_valid, req_write, req_addr,
      input  req_wdata, req_wstrb, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata
   );

endinterface

// File: rtl/param_memory_array.sv
// DEPTH x DW storage: one byte-masked write port, one async read port.
module param_memory_array
   import param_memory_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int AW = AW_DEF
) (
   input  logic            clk,
   input  logic            we,
   input  logic [AW-1:0]   waddr,
   input  logic [DW-1:0]   wdata,
   input  logic [DW/8-1:0] wmask,
   input  logic [AW-1:0]   raddr,
   output logic [DW-1:0]   rdata
);

   logic [DW-1:0] mem [2**AW];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < DW/8; i++) begin
            if (wmask[i]) begin
               mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
         end
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/param_memory.sv
// Single-port memory with req/rsp handshake, read latency and preload.
// Define MEM_BYTE_WRITE_EN to honour req_wstrb on request writes.
module param_memory
   import param_memory_pkg::*;
#(
   parameter int DW     = DW_DEF,
   parameter int AW     = AW_DEF,
   parameter int RD_LAT = RD_LAT_DEF
) (
   input  logic          clk,
   input  logic          rst,
   param_memory_if.slave bus,
   input  logic          load_start,
   input  logic          load_valid,
   input  logic [DW-1:0] load_data,
   output logic          load_busy,
   output logic          load_done
);

   localparam int SW = DW/8;

   state_t         state;
   logic [AW-1:0]  ptr;
   logic [AW-1:0]  cap_addr;
   logic [CNT_W-1:0] cnt;
   logic           rsp_valid_q;
   logic [DW-1:0]  rsp_rdata_q;

   logic           req_fire;
   logic           rd_fire;
   logic           wr_fire;
   logic           ld_fire;
   logic [SW-1:0]  req_mask;

   logic           we;
   logic [AW-1:0]  waddr;
   logic [DW-1:0]  wdata;
   logic [SW-1:0]  wmask;
   logic [AW-1:0]  raddr;
   logic [DW-1:0]  rdata;

   // load_start wins over a same-cycle request
   assign bus.req_ready = (state == IDLE) && !load_start && !rst;
   assign req_fire = bus.req_valid && bus.req_ready;
   assign wr_fire  = req_fire && bus.req_write;
   assign rd_fire  = req_fire && !bus.req_write;
   assign ld_fire  = (state == LOAD) && load_valid;

`ifdef MEM_BYTE_WRITE_EN
   assign req_mask = bus.req_wstrb;
`else
   logic unused_wstrb;
   assign unused_wstrb = ^bus.req_wstrb;
   assign req_mask = '1;
`endif

   always_comb begin
      we    = ld_fire || wr_fire;
      waddr = bus.req_addr;
      wdata = bus.req_wdata;
      wmask = req_mask;
      if (ld_fire) begin
         waddr = ptr;
         wdata = load_data;
         wmask = '1;
      end
   end

   assign raddr = (state == IDLE) ? bus.req_addr : cap_addr;

   param_memory_array #(
      .DW(DW),
      .AW(AW)
   ) u_array (
      .clk   (clk),
      .we    (we),
      .waddr (waddr),
      .wdata (wdata),
      .wmask (wmask),
      .raddr (raddr),
      .rdata (rdata)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         load_busy   <= 1'b0;
         load_done   <= 1'b0;
         ptr         <= '0;
         cnt         <= '0;
         cap_addr    <= '0;
      end else begin
         load_done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (load_start) begin
                  state     <= LOAD;
                  load_busy <= 1'b1;
                  ptr       <= '0;
               end else if (rd_fire) begin
                  cap_addr <= bus.req_addr;
                  cnt      <= CNT_W'(RD_LAT - 1);
                  if (RD_LAT == 1) begin
                     state       <= RESP;
                     rsp_valid_q <= 1'b1;
                     rsp_rdata_q <= rdata;
                  end else begin
                     state <= WAIT;
                  end
               end
            end
            LOAD: begin
               if (load_valid) begin
                  ptr <= ptr + 1'b1;
                  if (ptr == '1) begin
                     state     <= IDLE;
                     load_busy <= 1'b0;
                     load_done <= 1'b1;
                  end
               end
            end
            WAIT: begin
               if (cnt == '0) begin
                  state       <= RESP;
                  rsp_valid_q <= 1'b1;
                  rsp_rdata_q <= rdata;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  state       <= IDLE;
                  rsp_valid_q <= 1'b0;
                  rsp_rdata_q <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_param_memory.sv
// Scoreboard bench for param_memory (RD_LAT=3, 2048x32).
module tb_param_memory;

   localparam int DW     = 32;
   localparam int AW     = 11;
   localparam int DEPTH  = 2048;
   localparam int RD_LAT = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          load_start;
   logic          load_valid;
   logic [DW-1:0] load_data;
   logic          load_busy;
   logic          load_done;

   int checks   = 0;
   int failures = 0;
   logic [DW-1:0] sb [$];

   param_memory_if #(.DW(DW), .AW(AW)) bus ();

   param_memory #(
      .DW(DW),
      .AW(AW),
      .RD_LAT(RD_LAT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .load_start (load_start),
      .load_valid (load_valid),
      .load_data  (load_data),
      .load_busy  (load_busy),
      .load_done  (load_done)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic idle_inputs();
      load_start     = 1'b0;
      load_valid     = 1'b0;
      load_data      = '0;
      bus.req_valid  = 1'b0;
      bus.req_write  = 1'b0;
      bus.req_addr   = '0;
      bus.req_wdata  = '0;
      bus.req_wstrb  = '0;
      bus.rsp_ready  = 1'b1;
   endtask

   task automatic issue_req(input logic wr, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic [3:0] s,
                            input logic [DW-1:0] exp);
      int n;
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_write = wr;
      bus.req_addr  = a;
      bus.req_wdata = d;
      bus.req_wstrb = s;
      #1;
      n = 0;
      while (!bus.req_ready && n < 20) begin
         @(negedge clk);
         #1;
         n++;
      end
      checks++;
      if (!bus.req_ready) begin
         failures++;
         $display("FAIL req_accept got=0 exp=1 addr=%0d", a);
      end else if (!wr) begin
         sb.push_back(exp);
      end
      @(negedge clk);
      bus.req_valid = 1'b0;
      bus.req_write = 1'b0;
   endtask

   task automatic collect(input string name);
      int n;
      logic [DW-1:0] exp;
      n = 0;
      while (!bus.rsp_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      exp = (sb.size() != 0) ? sb.pop_front() : '0;
      checks++;
      if (!bus.rsp_valid) begin
         failures++;
         $display("FAIL %s timeout rsp_valid never rose", name);
      end else if (bus.rsp_rdata !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", name, bus.rsp_rdata, exp);
      end
      @(negedge clk);
      checks++;
      if (bus.rsp_valid !== 1'b0) begin
         failures++;
         $display("FAIL %s_release rsp_valid got=1 exp=0", name);
      end
   endtask

   task automatic stream_words(input int gap_at);
      for (int i = 0; i < DEPTH; i++) begin
         if (i == gap_at) begin
            load_valid = 1'b0;
            @(negedge clk);
         end
         load_valid = 1'b1;
         load_data  = DW'(i) ^ 32'hA5A5_0000;
         @(negedge clk);
      end
      load_valid = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b0 ||
          bus.rsp_rdata !== '0 || load_busy !== 1'b0 ||
          load_done !== 1'b0) begin
         failures++;
         $display("FAIL reset_state rdy=%b v=%b d=%h busy=%b done=%b exp=0",
                  bus.req_ready, bus.rsp_valid, bus.rsp_rdata,
                  load_busy, load_done);
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.req_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_release req_ready got=%b exp=1", bus.req_ready);
      end
   endtask

   task automatic test_preload();
      @(negedge clk);
      load_start = 1'b1;
      @(negedge clk);
      load_start = 1'b0;
      checks++;
      if (load_busy !== 1'b1 || bus.req_ready !== 1'b0) begin
         failures++;
         $display("FAIL preload_busy busy=%b rdy=%b exp busy=1 rdy=0",
                  load_busy, bus.req_ready);
      end
      stream_words(100);
      checks++;
      if (load_done !== 1'b1 || load_busy !== 1'b0) begin
         failures++;
         $display("FAIL preload_done done=%b busy=%b exp done=1 busy=0",
                  load_done, load_busy);
      end
      @(negedge clk);
      checks++;
      if (load_done !== 1'b0) begin
         failures++;
         $display("FAIL preload_pulse done=%b exp=0", load_done);
      end
   endtask

   task automatic test_back_to_back();
      logic [AW-1:0] addrs [3];
      addrs = '{11'd0, 11'd5, 11'd2047};
      foreach (addrs[k]) begin
         issue_req(1'b0, addrs[k], '0, '0,
                   32'hA5A5_0000 ^ DW'(addrs[k]));
         collect($sformatf("preload_rd_%0d", addrs[k]));
      end
   endtask

   task automatic test_latency();
      logic [DW-1:0] exp;
      exp = 32'hA5A5_0005;
      bus.rsp_ready = 1'b0;
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_write = 1'b0;
      bus.req_addr  = 11'd5;
      #1;
      checks++;
      if (bus.req_ready !== 1'b1) begin
         failures++;
         $display("FAIL lat_accept req_ready got=%b exp=1", bus.req_ready);
      end
      sb.push_back(exp);
      @(negedge clk);
      bus.req_valid = 1'b0;
      for (int k = 1; k <= RD_LAT; k++) begin
         checks++;
         if (bus.rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL lat_early cyc=%0d rsp_valid got=1 exp=0", k);
         end
         @(negedge clk);
      end
      exp = (sb.size() != 0) ? sb.pop_front() : '0;
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== exp) begin
         failures++;
         $display("FAIL lat_rise v=%b d=%h exp v=1 d=%h",
                  bus.rsp_valid, bus.rsp_rdata, exp);
      end
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         checks++;
         if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== exp ||
             bus.req_ready !== 1'b0) begin
            failures++;
            $display("FAIL lat_hold v=%b d=%h rdy=%b exp v=1 d=%h rdy=0",
                     bus.rsp_valid, bus.rsp_rdata, bus.req_ready, exp);
         end
      end
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== '0) begin
         failures++;
         $display("FAIL lat_drop v=%b d=%h exp v=0 d=0",
                  bus.rsp_valid, bus.rsp_rdata);
      end
   endtask

   task automatic test_write_read();
      issue_req(1'b1, 11'd12, 32'hDEAD_BEEF, 4'hF, '0);
      issue_req(1'b0, 11'd12, '0, '0, 32'hDEAD_BEEF);
      collect("write_read");
   endtask

   task automatic test_byte_strobe();
      logic [DW-1:0] exp;
`ifdef MEM_BYTE_WRITE_EN
      exp = 32'hDE22_BE44;
`else
      exp = 32'h1122_3344;
`endif
      issue_req(1'b1, 11'd12, 32'h1122_3344, 4'b0101, '0);
      issue_req(1'b0, 11'd12, '0, '0, exp);
      collect("byte_strobe");
   endtask

   task automatic test_priority();
      @(negedge clk);
      load_start    = 1'b1;
      bus.req_valid = 1'b1;
      bus.req_write = 1'b0;
      bus.req_addr  = 11'd7;
      #1;
      checks++;
      if (bus.req_ready !== 1'b0) begin
         failures++;
         $display("FAIL prio_ready got=%b exp=0", bus.req_ready);
      end
      @(negedge clk);
      load_start    = 1'b0;
      bus.req_valid = 1'b0;
      checks++;
      if (load_busy !== 1'b1 || bus.rsp_valid !== 1'b0) begin
         failures++;
         $display("FAIL prio_load busy=%b v=%b exp busy=1 v=0",
                  load_busy, bus.rsp_valid);
      end
      stream_words(-1);
      checks++;
      if (load_done !== 1'b1 || bus.rsp_valid !== 1'b0) begin
         failures++;
         $display("FAIL prio_done done=%b v=%b exp done=1 v=0",
                  load_done, bus.rsp_valid);
      end
   endtask

   task automatic test_reset_mid_read();
      logic seen;
      issue_req(1'b0, 11'd5, '0, '0, 32'hA5A5_0005);
      rst = 1'b1;
      #1;
      checks++;
      if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b0) begin
         failures++;
         $display("FAIL rst_read_hold v=%b rdy=%b exp 0 0",
                  bus.rsp_valid, bus.req_ready);
      end
      sb.delete();
      @(negedge clk);
      rst  = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         seen |= bus.rsp_valid;
      end
      checks++;
      if (seen !== 1'b0 || bus.req_ready !== 1'b1) begin
         failures++;
         $display("FAIL rst_read_abort seen=%b rdy=%b exp seen=0 rdy=1",
                  seen, bus.req_ready);
      end
      issue_req(1'b0, 11'd5, '0, '0, 32'hA5A5_0005);
      collect("rst_read_after");
   endtask

   task automatic test_reset_mid_load();
      @(negedge clk);
      load_start = 1'b1;
      @(negedge clk);
      load_start = 1'b0;
      for (int i = 0; i < 10; i++) begin
         load_valid = 1'b1;
         load_data  = DW'(i) ^ 32'h5A5A_0000;
         @(negedge clk);
      end
      load_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (load_busy !== 1'b0 || bus.req_ready !== 1'b1) begin
         failures++;
         $display("FAIL rst_load busy=%b rdy=%b exp busy=0 rdy=1",
                  load_busy, bus.req_ready);
      end
      issue_req(1'b0, 11'd3, '0, '0, 32'h5A5A_0003);
      collect("rst_load_kept");
      issue_req(1'b0, 11'd10, '0, '0, 32'hA5A5_000A);
      collect("rst_load_old");
   endtask

   initial begin
      test_reset();
      test_preload();
      test_back_to_back();
      test_latency();
      test_write_read();
      test_byte_strobe();
      test_priority();
      test_reset_mid_read();
      test_reset_mid_load();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
